// File: rtl/rk_sd_bridge_pkg.sv
// Shared constants and state encoding for the RK-to-SD block bridge.
package rk_sd_bridge_pkg;

  // One RK sector is 256 16-bit words, carried as one 512-byte SD sector.
  localparam int SD_BLOCK_WORDS = 256;
  localparam int SD_BLOCK_BYTES = 512;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RD_SPACE   = 3'd1,
    ST_RD_DATA    = 3'd2,
    ST_RD_PAD     = 3'd3,
    ST_WR_DATA    = 3'd4,
    ST_WR_DISCARD = 3'd5,
    ST_WAIT_IDLE  = 3'd6
  } state_t;

endpackage

// File: rtl/rk_sd_bridge_fifo.sv
// First-word-fall-through word FIFO with occupancy count and synchronous clear.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
module sd_word_fifo #(
  parameter int DATA_W = 16,
  parameter int AW     = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  localparam int DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic              push_ok;
  logic              pop_ok;

  assign full    = cnt[AW];
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle.
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  // Storage array; holds data only, so it is never reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rk_sd_bridge.sv
// Bridge between the RK controller's block handshake and a byte-serial SD
// sector engine. One RK sector (256 words) maps to one 512-byte SD sector,
// little-endian: the low byte of each word travels first.
module rk_sd_bridge
  import rk_sd_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_SECTOR  = 32'd0,
  parameter logic [31:0] DRIVE_STRIDE = 32'd4872,
  parameter logic [7:0]  DRIVE_MASK   = 8'h01,
  parameter logic [7:0]  WP_MASK      = 8'h00,
  parameter int          FIFO_AW      = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  sd_dev_sel,
  input  logic [12:0] sd_lba,
  input  logic        sd_read,
  input  logic        sd_write,
  output logic        sd_ready,
  output logic [7:0]  sd_loaded,
  output logic [7:0]  sd_write_protect,
  input  logic [15:0] sd_write_data,
  input  logic        sd_write_enable,
  output logic        sd_write_full,
  output logic [15:0] sd_read_data,
  input  logic        sd_read_enable,
  output logic        sd_read_empty,
  input  logic        sd_flush,
  output logic        sd_error,
  input  logic        sd_error_clr,
  input  logic        card_ready,
  input  logic        card_wp,
  output logic [31:0] blk_addr,
  output logic        blk_rd_start,
  output logic        blk_wr_start,
  input  logic        blk_busy,
  input  logic        blk_err,
  input  logic [7:0]  blk_rd_byte,
  input  logic        blk_rd_valid,
  output logic [7:0]  blk_wr_byte,
  input  logic        blk_wr_req
);

  localparam int               DATA_W      = 16;
  localparam logic [FIFO_AW:0] BLK_WORDS_C = (FIFO_AW+1)'(SD_BLOCK_WORDS);
  localparam logic [FIFO_AW:0] RD_ROOM_MAX = (FIFO_AW+1)'((1 << FIFO_AW) - SD_BLOCK_WORDS);
  localparam logic [9:0]       BYTES_C     = 10'(SD_BLOCK_BYTES);
  localparam logic [9:0]       LAST_BYTE_C = 10'(SD_BLOCK_BYTES - 1);
  localparam logic [8:0]       WORDS_C     = 9'(SD_BLOCK_WORDS);
  localparam logic [8:0]       LAST_WORD_C = 9'(SD_BLOCK_WORDS - 1);

  // Flat SD sector for a drive/LBA pair: each drive image is laid out back to back.
  function automatic logic [31:0] sector_addr(input logic [2:0] sel, input logic [12:0] lba);
    return BASE_SECTOR + 32'(sel) * DRIVE_STRIDE + 32'(lba);
  endfunction

  state_t              state, state_nxt;
  logic [9:0]          byte_cnt, byte_cnt_nxt;
  logic [8:0]          word_cnt, word_cnt_nxt;
  logic [7:0]          lo_byte;
  logic                err_set;
  logic                rd_start_nxt;
  logic                wr_start_nxt;
  logic                addr_load;
  logic                cmd;

  logic                rd_push;
  logic [DATA_W-1:0]   rd_din;
  logic                rd_full;
  logic [FIFO_AW:0]    rd_count;
  logic                wr_pop;
  logic [DATA_W-1:0]   wr_head;
  logic                wr_empty;
  logic [FIFO_AW:0]    wr_count;

  assign sd_loaded        = {8{card_ready}} & DRIVE_MASK;
  assign sd_write_protect = {8{card_wp}} | WP_MASK;
  assign sd_ready         = (state == ST_IDLE) & card_ready & ~blk_busy;
  assign cmd              = sd_read | sd_write;

  // Outside an active write (e.g. after a flush) the engine is fed zeros.
  assign blk_wr_byte = (state == ST_WR_DATA && !wr_empty)
                       ? (byte_cnt[0] ? wr_head[15:8] : wr_head[7:0]) : 8'h00;

  sd_word_fifo #(.DATA_W(DATA_W), .AW(FIFO_AW)) u_rd_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (sd_flush),
    .push    (rd_push & ~rd_full),
    .din     (rd_din),
    .pop     (sd_read_enable),
    .dout    (sd_read_data),
    .full    (rd_full),
    .empty   (sd_read_empty),
    .count   (rd_count)
  );

  sd_word_fifo #(.DATA_W(DATA_W), .AW(FIFO_AW)) u_wr_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (sd_flush),
    .push    (sd_write_enable),
    .din     (sd_write_data),
    .pop     (wr_pop & ~wr_empty),
    .dout    (wr_head),
    .full    (sd_write_full),
    .empty   (wr_empty),
    .count   (wr_count)
  );

  // Command decode, block sequencing and FIFO push/pop generation.
  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    word_cnt_nxt = word_cnt;
    rd_push      = 1'b0;
    rd_din       = '0;
    wr_pop       = 1'b0;
    err_set      = 1'b0;
    rd_start_nxt = 1'b0;
    wr_start_nxt = 1'b0;
    addr_load    = 1'b0;

    if (cmd && !sd_ready) err_set = 1'b1;

    case (state)
      ST_IDLE: begin
        if (cmd && sd_ready) begin
          if (sd_read && sd_write) begin
            err_set = 1'b1;
          end else if (sd_read) begin
            state_nxt    = ST_RD_SPACE;
            addr_load    = 1'b1;
            byte_cnt_nxt = '0;
            word_cnt_nxt = '0;
          end else if (wr_count >= BLK_WORDS_C && !sd_write_protect[sd_dev_sel]) begin
            state_nxt    = ST_WR_DATA;
            addr_load    = 1'b1;
            wr_start_nxt = 1'b1;
            byte_cnt_nxt = '0;
            word_cnt_nxt = '0;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      ST_RD_SPACE: begin
        if (rd_count <= RD_ROOM_MAX) begin
          rd_start_nxt = 1'b1;
          state_nxt    = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (blk_rd_valid && byte_cnt < BYTES_C) begin
          byte_cnt_nxt = byte_cnt + 10'd1;
          if (byte_cnt[0]) begin
            rd_push      = 1'b1;
            rd_din       = {blk_rd_byte, lo_byte};
            word_cnt_nxt = word_cnt + 9'd1;
          end
          if (byte_cnt == LAST_BYTE_C) state_nxt = ST_WAIT_IDLE;
        end
        if (blk_err && blk_busy) begin
          err_set   = 1'b1;
          state_nxt = ST_RD_PAD;
        end
      end
      ST_RD_PAD: begin
        // Zero-fill so the controller always sees a whole sector.
        if (word_cnt < WORDS_C) begin
          rd_push      = 1'b1;
          word_cnt_nxt = word_cnt + 9'd1;
        end
        if (word_cnt >= LAST_WORD_C) state_nxt = ST_WAIT_IDLE;
      end
      ST_WR_DATA: begin
        if (blk_wr_req && byte_cnt < BYTES_C) begin
          byte_cnt_nxt = byte_cnt + 10'd1;
          if (byte_cnt[0]) begin
            wr_pop       = 1'b1;
            word_cnt_nxt = word_cnt + 9'd1;
          end
          if (byte_cnt == LAST_BYTE_C) state_nxt = ST_WAIT_IDLE;
        end
        if (blk_err && blk_busy) begin
          err_set   = 1'b1;
          state_nxt = ST_WR_DISCARD;
        end
      end
      ST_WR_DISCARD: begin
        // Drop the unsent remainder of the block so the next one starts aligned.
        if (word_cnt < WORDS_C) begin
          wr_pop       = 1'b1;
          word_cnt_nxt = word_cnt + 9'd1;
        end
        if (word_cnt >= LAST_WORD_C) state_nxt = ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (!blk_busy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Flush abandons the current block; the engine finishes on its own.
    if (sd_flush) begin
      state_nxt    = ST_WAIT_IDLE;
      byte_cnt_nxt = '0;
      word_cnt_nxt = '0;
      rd_push      = 1'b0;
      wr_pop       = 1'b0;
      rd_start_nxt = 1'b0;
      wr_start_nxt = 1'b0;
      addr_load    = 1'b0;
    end
  end

  // Control state, counters, start pulses, latched address and sticky error.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      byte_cnt     <= '0;
      word_cnt     <= '0;
      blk_rd_start <= 1'b0;
      blk_wr_start <= 1'b0;
      blk_addr     <= '0;
      sd_error     <= 1'b0;
    end else begin
      state        <= state_nxt;
      byte_cnt     <= byte_cnt_nxt;
      word_cnt     <= word_cnt_nxt;
      blk_rd_start <= rd_start_nxt;
      blk_wr_start <= wr_start_nxt;
      if (addr_load) blk_addr <= sector_addr(sd_dev_sel, sd_lba);
      if (err_set)           sd_error <= 1'b1;
      else if (sd_error_clr) sd_error <= 1'b0;
    end
  end

  // Holds the even (low) byte until its odd partner completes the word.
  always_ff @(posedge clk) begin
    if (state == ST_RD_DATA && blk_rd_valid && !byte_cnt[0]) lo_byte <= blk_rd_byte;
  end

endmodule
